// File: rtl/pc_seq.sv
// ---------------------------------------------------------------------------
// pc_seq -- program-counter sequencer for the fetch stage.
//
// Holds the current fetch address. Each clock it advances by STEP, holds on
// stall, or redirects on branch (relative), jump (absolute), call or return.
// When the computed next pc reaches or passes END_ADDR the sequencer clamps
// pc to END_ADDR, halts, and raises done until the next reset.
//
// Optional feature macro: PC_SEQ_RAS_EN
//   defined   : RAS_DEPTH-entry circular return-address stack; call with
//               jump_en pushes pc+STEP, ret pops into pc.
//   undefined : no stack; call and ret are ignored; ras_ovf/ras_unf are 0.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   stall      in   hold pc, ignore all commands this cycle
//   branch_en  in   pc <- pc + branch_off
//   branch_off in   [WIDTH] two's-complement offset
//   jump_en    in   pc <- jump_addr
//   jump_addr  in   [WIDTH] absolute target
//   call       in   with jump_en: also push pc+STEP
//   ret        in   pc <- popped return address
//   pc_out     out  [WIDTH] current fetch address (registered)
//   pc_valid   out  pc_out is a live fetch address
//   done       out  sequencer halted at END_ADDR
//   ras_ovf    out  one-cycle pulse: push onto a full stack
//   ras_unf    out  one-cycle pulse: ret with an empty stack
// ---------------------------------------------------------------------------
module pc_seq #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] STEP       = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR = 0,
    parameter logic [WIDTH-1:0] END_ADDR   = 132,
    parameter int unsigned      RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_off,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_out,
    output logic             pc_valid,
    output logic             done,
    output logic             ras_ovf,
    output logic             ras_unf
);

    localparam int unsigned RAS_AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] nxt_pc;

    // Stack-side view seen by the next-pc logic.
    logic             ret_pop;    // ret with a non-empty stack
    logic             ret_empty;  // ret with an empty stack
    logic             call_ok;    // call is honoured in this build
    logic [WIDTH-1:0] ras_top;

    // Requests from the next-pc logic to the stack.
    logic             push_req;
    logic             pop_req;
    logic             unf_req;
    logic [WIDTH-1:0] push_val;

    assign push_val = pc_q + STEP;

    // -----------------------------------------------------------------------
    // Next-state / next-pc
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        nxt_pc   = pc_q + STEP;
        push_req = 1'b0;
        pop_req  = 1'b0;
        unf_req  = 1'b0;
        case (state_q)
            // Release from reset is absorbed here: pc is kept and only the
            // state moves, so the first live address is RESET_ADDR.
            INIT: state_d = RUN;
            RUN: begin
                if (!stall) begin
                    if (ret_pop) begin
                        nxt_pc  = ras_top;
                        pop_req = 1'b1;
                    end else if (ret_empty) begin
                        // Empty-stack return falls back to a plain advance;
                        // it still outranks jump/branch.
                        nxt_pc  = pc_q + STEP;
                        unf_req = 1'b1;
                    end else if (jump_en) begin
                        nxt_pc   = jump_addr;
                        push_req = call & call_ok;
                    end else if (branch_en) begin
                        // Two's-complement offset: modulo add gives the
                        // signed result without sign extension.
                        nxt_pc = pc_q + branch_off;
                    end

                    if (nxt_pc >= END_ADDR) begin
                        pc_d    = END_ADDR;
                        state_d = HALT;
                    end else begin
                        pc_d = nxt_pc;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            pc_q    <= RESET_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_out   = pc_q;
    assign pc_valid = (state_q != INIT);
    assign done     = (state_q == HALT);

`ifdef PC_SEQ_RAS_EN
    // -----------------------------------------------------------------------
    // Return-address stack: circular buffer, ras_wp_q is the next write slot.
    // When full, the next write slot holds the oldest entry, so a push simply
    // overwrites it while the count saturates.
    // -----------------------------------------------------------------------
    localparam logic [RAS_AW-1:0] RAS_LAST = RAS_AW'(RAS_DEPTH - 1);
    localparam logic [RAS_AW:0]   RAS_FULL = (RAS_AW + 1)'(RAS_DEPTH);

    logic [WIDTH-1:0]  ras_mem [RAS_DEPTH];
    logic [RAS_AW-1:0] ras_wp_q;
    logic [RAS_AW:0]   ras_cnt_q;
    logic [RAS_AW-1:0] wp_inc;
    logic [RAS_AW-1:0] wp_dec;
    logic              ras_full;
    logic              ovf_q;
    logic              unf_q;

    assign wp_inc    = (ras_wp_q == RAS_LAST) ? '0 : ras_wp_q + 1'b1;
    assign wp_dec    = (ras_wp_q == '0) ? RAS_LAST : ras_wp_q - 1'b1;
    assign ras_full  = (ras_cnt_q == RAS_FULL);
    assign ras_top   = ras_mem[wp_dec];
    assign ret_pop   = ret & (ras_cnt_q != '0);
    assign ret_empty = ret & (ras_cnt_q == '0);
    assign call_ok   = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_wp_q  <= '0;
            ras_cnt_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            ovf_q <= push_req & ras_full;
            unf_q <= unf_req;
            if (push_req) begin
                ras_wp_q <= wp_inc;
                if (!ras_full) begin
                    ras_cnt_q <= ras_cnt_q + 1'b1;
                end
            end else if (pop_req) begin
                ras_wp_q  <= wp_dec;
                ras_cnt_q <= ras_cnt_q - 1'b1;
            end
        end
    end

    // Entries are qualified by the count, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (push_req) begin
            ras_mem[ras_wp_q] <= push_val;
        end
    end

    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;
`else
    assign ret_pop   = 1'b0;
    assign ret_empty = 1'b0;
    assign call_ok   = 1'b0;
    assign ras_top   = '0;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;

    // call/ret and the stack request lines have no consumer in this build.
    logic [RAS_AW-1:0] unused_ras_aw;
    logic              unused_ras;
    assign unused_ras_aw = '0;
    assign unused_ras    = &{1'b0, call, ret, push_req, pop_req, unf_req,
                             push_val, unused_ras_aw};
`endif

endmodule

// File: tb/tb_pc_seq.sv
// ---------------------------------------------------------------------------
// tb_pc_seq -- directed bench for pc_seq.
// u_a: default parameters (END_ADDR 132, RAS_DEPTH 4).
// u_b: END_ADDR 0x200, RAS_DEPTH 2, for call/return sequences.
// Inputs are shared; the instance not under test is held in reset.
// Expectations follow PC_SEQ_RAS_EN as seen by this compilation.
// ---------------------------------------------------------------------------
module tb_pc_seq;

`ifdef PC_SEQ_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        stall, branch_en, jump_en, call, ret;
    logic [31:0] branch_off, jump_addr;

    logic [31:0] pc_a, pc_b;
    logic        val_a, done_a, ovf_a, unf_a;
    logic        val_b, done_b, ovf_b, unf_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_seq u_a (
        .clk(clk), .rst(rst_a), .stall(stall),
        .branch_en(branch_en), .branch_off(branch_off),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .call(call), .ret(ret),
        .pc_out(pc_a), .pc_valid(val_a), .done(done_a),
        .ras_ovf(ovf_a), .ras_unf(unf_a)
    );

    pc_seq #(.END_ADDR(32'h200), .RAS_DEPTH(2)) u_b (
        .clk(clk), .rst(rst_b), .stall(stall),
        .branch_en(branch_en), .branch_off(branch_off),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .call(call), .ret(ret),
        .pc_out(pc_b), .pc_valid(val_b), .done(done_b),
        .ras_ovf(ovf_b), .ras_unf(unf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [31:0] epc, input logic ev,
                         input logic ed, input logic eo, input logic eu);
        chk({tag, ".pc"},    pc_a,          epc);
        chk({tag, ".valid"}, {31'd0, val_a}, {31'd0, ev});
        chk({tag, ".done"},  {31'd0, done_a}, {31'd0, ed});
        chk({tag, ".ovf"},   {31'd0, ovf_a}, {31'd0, eo});
        chk({tag, ".unf"},   {31'd0, unf_a}, {31'd0, eu});
    endtask

    task automatic chk_b(input string tag, input logic [31:0] epc, input logic ev,
                         input logic ed, input logic eo, input logic eu);
        chk({tag, ".pc"},    pc_b,          epc);
        chk({tag, ".valid"}, {31'd0, val_b}, {31'd0, ev});
        chk({tag, ".done"},  {31'd0, done_b}, {31'd0, ed});
        chk({tag, ".ovf"},   {31'd0, ovf_b}, {31'd0, eo});
        chk({tag, ".unf"},   {31'd0, unf_b}, {31'd0, eu});
    endtask

    task automatic cmd(input logic st, input logic br, input logic [31:0] off,
                       input logic jp, input logic [31:0] ja, input logic cl, input logic rt);
        stall      = st;
        branch_en  = br;
        branch_off = off;
        jump_en    = jp;
        jump_addr  = ja;
        call       = cl;
        ret        = rt;
    endtask

    task automatic idle();
        cmd(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        idle();
        step();
        step();

        // ---------------- instance A: default parameters ----------------
        chk_a("a_reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_a = 1'b0;
        step(); chk_a("a_init_exit", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); chk_a("a_run1", 32'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); chk_a("a_run2", 32'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        step(); chk_a("a_run4", 32'd16, 1'b1, 1'b0, 1'b0, 1'b0);

        cmd(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'd0, 1'b0, 1'b0);
        step(); chk_a("a_branch_neg", 32'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd(1'b1, 1'b0, 32'd0, 1'b1, 32'h40, 1'b0, 1'b0);
        step(); chk_a("a_stall_jump", 32'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b0, 1'b0);
        step(); chk_a("a_jump", 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);

        idle();
        for (int i = 1; i <= 16; i++) begin
            step(); chk_a("a_freerun", 32'd64 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(); chk_a("a_end", 32'd132, 1'b1, 1'b1, 1'b0, 1'b0);
        cmd(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(); chk_a("a_halt_branch", 32'd132, 1'b1, 1'b1, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 32'd0, 1'b1, 32'h8, 1'b0, 1'b0);
        step(); chk_a("a_halt_jump", 32'd132, 1'b1, 1'b1, 1'b0, 1'b0);

        idle();
        rst_a = 1'b1;
        #1; chk_a("a_async_rst", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_a = 1'b0;
        step(); chk_a("a_rerun", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        cmd(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(); chk_a("a_ret_alone", 32'd4, 1'b1, 1'b0, 1'b0, RAS);
        cmd(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(); chk_a("a_call_alone", 32'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 32'd0, 1'b1, 32'h1000, 1'b0, 1'b0);
        step(); chk_a("a_jump_past_end", 32'd132, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        step(); chk_a("a_halt_hold", 32'd132, 1'b1, 1'b1, 1'b0, 1'b0);
        rst_a = 1'b1;

        // ---------------- instance B: END 0x200, RAS_DEPTH 2 ----------------
        rst_b = 1'b0;
        step(); chk_b("b_init_exit", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); step(); step();
        step(); chk_b("b_at_10", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 32'd0, 1'b1, 32'h80, 1'b1, 1'b0);
        step(); chk_b("b_call", 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(); chk_b("b_ret1", RAS ? 32'h14 : 32'h84, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); chk_b("b_ret_empty", RAS ? 32'h18 : 32'h88, 1'b1, 1'b0, 1'b0, RAS);
        idle();
        step(); chk_b("b_unf_clear", RAS ? 32'h1C : 32'h8C, 1'b1, 1'b0, 1'b0, 1'b0);

        rst_b = 1'b1;
        #1; chk_b("b_async_rst", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_b = 1'b0;
        step(); step(); step(); step();
        step(); chk_b("b2_at_10", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 32'd0, 1'b1, 32'h20, 1'b1, 1'b0);
        step(); chk_b("b2_call1", 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 32'd0, 1'b1, 32'h30, 1'b1, 1'b0);
        step(); chk_b("b2_call2", 32'h30, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b1, 1'b0);
        step(); chk_b("b2_call3_ovf", 32'h40, 1'b1, 1'b0, RAS, 1'b0);
        cmd(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(); chk_b("b2_stall_ret", 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(); chk_b("b2_ret1", RAS ? 32'h34 : 32'h44, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); chk_b("b2_ret2", RAS ? 32'h24 : 32'h48, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); chk_b("b2_ret3_unf", RAS ? 32'h28 : 32'h4C, 1'b1, 1'b0, 1'b0, RAS);
        idle();
        step(); chk_b("b2_after", RAS ? 32'h2C : 32'h50, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_b = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the processor fetch stage. Holds the current fetch address and, each clock, advances it by a fixed step, holds it on stall, or redirects it on branch, jump, call or return. It clamps at a configurable end-of-program address, where it halts and flags completion. An optional return-address stack supports call/return.

## Interface
Parameters:
- WIDTH, 32, address width in bits
- STEP, 4, increment added per normal advance
- RESET_ADDR, 0, pc value held in and immediately after reset
- END_ADDR, 132, end-of-program address; reaching or passing it halts the sequencer
- RAS_DEPTH, 4, return-address stack entries (≥2; used only with PC_SEQ_RAS_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold pc; all commands ignored this cycle
- branch_en  in  1  relative redirect
- branch_off  in  WIDTH  signed two's-complement offset, added to current pc
- jump_en  in  1  absolute redirect
- jump_addr  in  WIDTH  absolute target
- call  in  1  qualifies jump_en: also push pc+STEP onto RAS
- ret  in  1  redirect to popped RAS entry
- pc_out  out  WIDTH  current fetch address (registered)
- pc_valid  out  1  pc_out is a live fetch address
- done  out  1  sequencer halted at END_ADDR
- ras_ovf  out  1  one-cycle pulse: push onto full RAS
- ras_unf  out  1  one-cycle pulse: ret with empty RAS

## Operation
- FSM states: INIT, RUN, HALT.
- INIT: entered on rst. pc=RESET_ADDR, pc_valid=0. The first rising edge after rst deasserts moves to RUN with pc unchanged and pc_valid=1. Commands are ignored in INIT.
- RUN, next-pc priority (highest first):
  - stall: hold pc.
  - ret (RAS built in, stack non-empty): pc ← top of stack, pop.
  - jump_en: pc ← jump_addr. If call is also set, push pc+STEP.
  - branch_en: pc ← pc+branch_off.
  - default: pc ← pc+STEP.
- call without jump_en has no effect. ret and jump_en together: ret wins, and no push occurs.
- Arithmetic is unsigned modulo 2^WIDTH, so wrap-around is silent. The END_ADDR comparison is unsigned on the computed next pc.
- If the computed next pc ≥ END_ADDR: pc ← END_ADDR, go to HALT, done=1. This applies to any source, including jump targets.
- HALT: pc_out held at END_ADDR, pc_valid=1, done=1. All inputs are ignored. Only rst exits HALT.
- RAS is a circular stack of RAS_DEPTH entries with a count.
  - Push when full overwrites the oldest entry, keeps count=RAS_DEPTH, and pulses ras_ovf.
  - ret when empty is treated as the default increment and pulses ras_unf.
  - A stalled cycle never pushes or pops.
- rst mid-operation: state returns to INIT immediately. RAS is emptied and flags cleared.

## Timing
- Reset values: pc_out=RESET_ADDR, pc_valid=0, done=0, ras_ovf=0, ras_unf=0, RAS count=0.
- Commands are sampled on rising edge N. The new pc_out is visible after edge N, giving one-cycle latency. There is no combinational path from inputs to pc_out.
- done asserts in the same cycle that pc_out first shows END_ADDR.
- ras_ovf and ras_unf are registered. They are high for exactly the one cycle following the offending edge.
- rst deassertion is synchronised internally by the INIT→RUN step. pc_valid rises one edge after release.

## Configuration
- PC_SEQ_RAS_EN defined: RAS, call push and ret pop are built as described.
- PC_SEQ_RAS_EN undefined:
  - No stack storage.
  - call and ret are ignored, so a cycle with only ret asserted advances by STEP.
  - ras_ovf and ras_unf are tied to 0.
  - RAS_DEPTH is unused.

## Test plan
All scenarios use the default parameters unless stated.
- Reset then run 3 cycles with no commands → pc_out 0 (valid=0), 0 (valid=1), 4, 8.
- At pc=16: branch_en with off=-8 → 8. At pc=8: jump_en to 0x40 with stall=1 → stays 8. Next cycle without stall → 0x40.
- At pc=0x10: jump_en+call to 0x80 with END_ADDR raised to 0x200 → 0x80. Then ret → 0x14, RAS empty. A second ret → 0x18 with ras_unf pulse.
- RAS_DEPTH=2: three calls from 0x10, 0x20, 0x30 → ras_ovf on the third. Two rets return 0x34, 0x24. A third ret gives ras_unf.
- Free run to end → pc_out 128 then 132 with done=1. Further branch or jump inputs have no effect. rst then gives pc_out=0, done=0.
- jump_en to 0x1000 → pc_out=132 and done=1 next cycle. Without PC_SEQ_RAS_EN, ret alone advances by 4 and both RAS flags stay 0.
